cory_sram_ro_arb: RTL

CORY_SRAM_RO_ARB -- requirements
Module: cory_sram_ro_arb

---
 rtl/cory_sram_ro_arb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cory_sram_ro_arb.sv
// Two-requester round-robin arbiter in front of an in-order SRAM read-only wrapper.
// Requests from A and B share one request channel (z). A Q-deep tag FIFO records
// which requester each read belongs to, so the in-order read data can be routed back.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_a_v/i_a_addr/o_a_r         requester A read request (valid/address/ready)
//   o_a_v/o_a_d/i_a_r            requester A read data (valid/data/ready)
//   i_b_* / o_b_*                requester B, same roles as A
//   o_z_v/o_z_addr/i_z_r         shared read request to the wrapper
//   i_z_v/i_z_d/o_z_r            shared in-order read data from the wrapper
module cory_sram_ro_arb #(
  parameter int unsigned A = 8,
  parameter int unsigned D = 8,
  parameter int unsigned Q = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a_v,
  input  logic [A-1:0] i_a_addr,
  output logic         o_a_r,
  output logic         o_a_v,
  output logic [D-1:0] o_a_d,
  input  logic         i_a_r,
  input  logic         i_b_v,
  input  logic [A-1:0] i_b_addr,
  output logic         o_b_r,
  output logic         o_b_v,
  output logic [D-1:0] o_b_d,
  input  logic         i_b_r,
  output logic         o_z_v,
  output logic [A-1:0] o_z_addr,
  input  logic         i_z_r,
  input  logic         i_z_v,
  input  logic [D-1:0] i_z_d,
  output logic         o_z_r
);

  localparam int unsigned PW = (Q > 1) ? $clog2(Q) : 1;
  localparam int unsigned CW = $clog2(Q + 1);

  // Lock states pin the grant on a requester whose request is stalled.
  typedef enum logic [1:0] {ST_FREE, ST_LOCK_A, ST_LOCK_B} state_t;

  state_t        state, state_nxt;
  logic          last_b, last_b_nxt;
  logic [Q-1:0]  tag_mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, head_b;
  logic          gnt_v, gnt_b;
  logic          push, pop;

  assign full   = (count == CW'(Q));
  assign empty  = (count == '0);
  assign head_b = tag_mem[rd_ptr];

  // Grant selection, request channel outputs and lock next-state.
  always_comb begin
    state_nxt  = state;
    last_b_nxt = last_b;
    gnt_v      = 1'b0;
    gnt_b      = 1'b0;
    o_z_v      = 1'b0;
    o_z_addr   = '0;
    o_a_r      = 1'b0;
    o_b_r      = 1'b0;
    push       = 1'b0;

    unique case (state)
      ST_LOCK_A: begin
        gnt_v = 1'b1;
        gnt_b = 1'b0;
      end
      ST_LOCK_B: begin
        gnt_v = 1'b1;
        gnt_b = 1'b1;
      end
      default: begin
        if (i_a_v && i_b_v) begin
          gnt_v = 1'b1;
          gnt_b = ~last_b;
        end else if (i_a_v) begin
          gnt_v = 1'b1;
        end else if (i_b_v) begin
          gnt_v = 1'b1;
          gnt_b = 1'b1;
        end
      end
    endcase

    if (reset_n && gnt_v) begin
      o_z_v    = (gnt_b ? i_b_v : i_a_v) && !full;
      o_z_addr = gnt_b ? i_b_addr : i_a_addr;
      o_a_r    = !gnt_b && i_z_r && !full;
      o_b_r    = gnt_b && i_z_r && !full;
    end

    push = o_z_v && i_z_r;
    if (push) begin
      state_nxt  = ST_FREE;
      last_b_nxt = gnt_b;
    end else if (o_z_v && (!i_z_r || full)) begin
      state_nxt = gnt_b ? ST_LOCK_B : ST_LOCK_A;
    end
  end

  // Read data routing by the FIFO head tag; zero latency.
  always_comb begin
    o_a_d = i_z_d;
    o_b_d = i_z_d;
    o_a_v = reset_n && !empty && i_z_v && !head_b;
    o_b_v = reset_n && !empty && i_z_v && head_b;
    o_z_r = reset_n && !empty && (head_b ? i_b_r : i_a_r);
    pop   = i_z_v && o_z_r;
  end

  // Arbiter state; B is "last granted" out of reset so A wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_FREE;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_b <= last_b_nxt;
    end
  end

  // Outstanding-tag FIFO; pointers wrap naturally since Q is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= gnt_b;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef SIM
  // Read data with no outstanding tag cannot be routed.
  always @(posedge clk) begin
    if (reset_n && i_z_v && empty) begin
      $display("ERROR: cory_sram_ro_arb read data returned with no outstanding tag");
      $finish;
    end
  end
`endif

endmodule
